// File: rtl/jtframe_rom_pkg.sv
// Shared types for the SDRAM ROM read-port arbiter.
// FSM encoding and default SDRAM word address width.
package jtframe_rom_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } rom_arb_st_t;

endpackage

// File: rtl/jtframe_rr_arbiter.sv
// Combinational round-robin picker: first needing slot
// at or after ptr, wrapping SLOTS-1 -> 0.
module jtframe_rr_arbiter #(
  parameter int SLOTS = 4,
  parameter int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS-1:0] need,
  input  logic [IW-1:0]    ptr,
  output logic [SLOTS-1:0] gnt,
  output logic [IW-1:0]    idx
);

  int j;

  // Walk from farthest to nearest so the nearest winner is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % SLOTS;
      if (need[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_arbiter.sv
// Shares one SDRAM ROM read port among SLOTS clients,
// with a one-word cache per slot and round-robin grant.
module jtframe_rom_arbiter
  import jtframe_rom_pkg::*;
#(
  parameter int                  SLOTS       = 4,
  parameter int                  AW          = SDRAM_AW,
  parameter logic [SLOTS*AW-1:0] SLOT_OFFSET = '0
) (
  input  logic                  clk_rom,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic                  loop_rst,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [AW-1:0]         sdram_addr,
  input  logic [31:0]           data_read,
  input  logic                  data_rdy
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  rom_arb_st_t st_q, st_d;

  logic [IW-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       saddr_q, saddr_d;
  logic                req_q, req_d;
  logic [SLOTS-1:0]    valid_q, valid_d;
  logic [SLOTS-1:0]    ok_q, ok_d;
  logic [AW-1:0]       tag_q [SLOTS];
  logic [AW-1:0]       tag_d [SLOTS];
  logic [SLOTS*32-1:0] dout_q, dout_d;

  logic [AW-1:0]    addr_w [SLOTS];
  logic [AW-1:0]    off_w  [SLOTS];
  logic [SLOTS-1:0] hit, need, fill_hit;
  logic [SLOTS-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             flush, fill;

  assign flush = downloading | loop_rst;

  // A fill lands only while a request is outstanding and not flushed
  assign fill = ~flush & data_rdy &
                ((st_q == WAIT_RDY) |
                 ((st_q == WAIT_ACK) & sdram_ack));

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_w[i]   = slot_addr[i*AW +: AW];
    assign off_w[i]    = SLOT_OFFSET[i*AW +: AW];
    assign hit[i]      = valid_q[i] & (tag_q[i] == addr_w[i]);
    assign need[i]     = slot_req[i] & ~hit[i];
    assign fill_hit[i] = fill & (gnt_q == IW'(i)) &
                         (addr_q == addr_w[i]);
    assign ok_d[i]     = ~flush & slot_req[i] &
                         (hit[i] | fill_hit[i]);
  end

  jtframe_rr_arbiter #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_rr (
    .need (need),
    .ptr  (rr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    st_d    = st_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    saddr_d = saddr_q;
    req_d   = req_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    dout_d  = dout_q;
    if (flush) begin
      st_d    = IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (|arb_gnt) begin
            gnt_d   = arb_idx;
            addr_d  = addr_w[arb_idx];
            saddr_d = addr_w[arb_idx] + off_w[arb_idx];
            req_d   = 1'b1;
            st_d    = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_d = 1'b0;
            st_d  = WAIT_RDY;
          end
        end
        WAIT_RDY: ;
        default: st_d = IDLE;
      endcase
      if (fill) begin
        st_d                       = IDLE;
        valid_d[gnt_q]             = 1'b1;
        tag_d[gnt_q]               = addr_q;
        dout_d[int'(gnt_q)*32 +: 32] = data_read;
        rr_d = (gnt_q == IW'(SLOTS - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      saddr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= '0;
      ok_q    <= '0;
      dout_q  <= '0;
      for (int i = 0; i < SLOTS; i++) tag_q[i] <= '0;
    end else begin
      st_q    <= st_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      saddr_q <= saddr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      dout_q  <= dout_d;
      tag_q   <= tag_d;
    end
  end

  assign slot_ok    = ok_q;
  assign slot_dout  = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

endmodule
